// File: rtl/fpu_lzd_sched.sv
// Shared leading-zero detector for two requesters (FMADD=0, FADD=1), round-robin arbitrated, 2-stage pipeline.
// Latency 2 cycles; one-entry skid in S1 absorbs a result stall. Optional normalizer: FPU_LZD_NORM_SHIFT_EN.
module fpu_lzd_sched #(
  parameter int MANT_W = 24,
  parameter int LZC_W  = 5
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              req0_valid,
  input  logic [MANT_W-1:0] req0_mant,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [MANT_W-1:0] req1_mant,
  output logic              req1_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_owner,
  output logic [LZC_W-1:0]  res_lzc,
  output logic              res_zero,
  output logic [MANT_W-1:0] res_mant
);

  logic              rr_last;
  logic              s1_vld;
  logic              s1_own;
  logic [MANT_W-1:0] s1_mant;

  logic              stall;
  logic              s1_free;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic [LZC_W-1:0]  lzc;
  logic [MANT_W-1:0] mant_out;

  assign stall   = res_valid & ~res_ready;
  // S1 can take a new operand if empty, or if its current entry moves to S2 this cycle.
  assign s1_free = ~s1_vld | ~stall;

  always_comb begin
    gnt1 = req1_valid & (~req0_valid | ~rr_last);
    gnt0 = req0_valid & ~gnt1;
  end

  assign req0_ready = rst_l & s1_free & gnt0;
  assign req1_ready = rst_l & s1_free & gnt1;
  assign accept     = req0_ready | req1_ready;

  // Upward scan: the highest set bit is the last one written.
  always_comb begin
    lzc = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (s1_mant[i]) lzc = LZC_W'(MANT_W - 1 - i);
    end
  end

`ifdef FPU_LZD_NORM_SHIFT_EN
  assign mant_out = s1_mant << lzc;
`else
  assign mant_out = s1_mant;
`endif

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rr_last   <= 1'b1;
      s1_vld    <= 1'b0;
      s1_own    <= 1'b0;
      s1_mant   <= '0;
      res_valid <= 1'b0;
      res_owner <= 1'b0;
      res_lzc   <= '0;
      res_zero  <= 1'b0;
      res_mant  <= '0;
    end else begin
      if (accept) rr_last <= req1_ready;
      if (s1_free) begin
        s1_vld <= accept;
        if (accept) begin
          s1_own  <= req1_ready;
          s1_mant <= req1_ready ? req1_mant : req0_mant;
        end
      end
      if (!stall) begin
        res_valid <= s1_vld;
        if (s1_vld) begin
          res_owner <= s1_own;
          res_lzc   <= lzc;
          res_zero  <= (s1_mant == '0);
          res_mant  <= mant_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_lzd_sched.sv
// Directed bench for fpu_lzd_sched: latency, arbitration, stall/skid, reset discard.
module tb_fpu_lzd_sched;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_mant, req1_mant;
  logic        res_valid, res_ready, res_owner, res_zero;
  logic [4:0]  res_lzc;
  logic [23:0] res_mant;

  int tests_run = 0;
  int tests_failed = 0;

  fpu_lzd_sched dut (
    .clk(clk), .rst_l(rst_l),
    .req0_valid(req0_valid), .req0_mant(req0_mant), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_mant(req1_mant), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_owner(res_owner),
    .res_lzc(res_lzc), .res_zero(res_zero), .res_mant(res_mant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    tick(); tick();
    rst_l = 1'b1;
  endtask

  function automatic logic [23:0] norm(input logic [23:0] raw, input logic [23:0] shifted);
`ifdef FPU_LZD_NORM_SHIFT_EN
    return shifted;
`else
    return raw;
`endif
  endfunction

  // One operand from requester r, checked 2 cycles after the handshake.
  task automatic single(input logic r, input logic [23:0] m, input logic [4:0] elzc,
                        input logic ezero, input logic [23:0] eshift);
    req0_valid = ~r; req1_valid = r; req0_mant = m; req1_mant = m; res_ready = 1'b1;
    #1;
    check("single_ready", {req1_ready, req0_ready}, r ? 32'h2 : 32'h1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("single_gap", res_valid, 1'b0);
    tick();
    check("single_vld", res_valid, 1'b1);
    check("single_own", res_owner, r);
    check("single_lzc", res_lzc, elzc);
    check("single_zero", res_zero, ezero);
    check("single_mant", res_mant, norm(m, eshift));
    tick();
    check("single_idle", res_valid, 1'b0);
  endtask

  logic [23:0] smant [4] = '{24'h100000, 24'h010000, 24'h001000, 24'h000010};
  logic [4:0]  slzc  [4] = '{5'd3, 5'd7, 5'd11, 5'd19};
  logic        s_rdy [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
  int          s_res [10] = '{-1, -1, 0, 0, 0, 0, 1, 2, 3, -1};

  initial begin
    req0_mant = '0; req1_mant = '0;
    // Reset state, readys held low with valids asserted
    rst_l = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    tick(); tick();
    check("rst_vld", res_valid, 1'b0);
    check("rst_own", res_owner, 1'b0);
    check("rst_lzc", res_lzc, 5'd0);
    check("rst_zero", res_zero, 1'b0);
    check("rst_mant", res_mant, 24'h0);
    check("rst_rdy", {req1_ready, req0_ready}, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0; rst_l = 1'b1;
    tick();

    single(1'b0, 24'h00F000, 5'd8,  1'b0, 24'hF00000);
    single(1'b1, 24'h000000, 5'd24, 1'b1, 24'h000000);
    single(1'b0, 24'h800000, 5'd0,  1'b0, 24'h800000);
    single(1'b1, 24'h000001, 5'd23, 1'b0, 24'h800000);

    // Contended stream right after reset: grants 0,1,0,1
    do_reset();
    req0_mant = 24'h400000; req1_mant = 24'h000100;
    for (int k = 0; k < 7; k++) begin
      if (k >= 2 && k < 6) begin
        check("rr_res_vld", res_valid, 1'b1);
        check("rr_res_own", res_owner, (k % 2 == 1));
        check("rr_res_lzc", res_lzc, (k % 2 == 1) ? 5'd15 : 5'd1);
      end else begin
        check("rr_res_idle", res_valid, 1'b0);
      end
      req0_valid = (k < 4); req1_valid = (k < 4);
      #1;
      if (k < 4) check("rr_grant", {req1_ready, req0_ready}, (k % 2 == 1) ? 32'h2 : 32'h1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Stall with skid: res_ready low for cycles 2..4
    do_reset();
    begin
      int idx = 0;
      for (int k = 0; k < 10; k++) begin
        res_ready = !(k >= 2 && k <= 4);
        if (s_res[k] < 0) begin
          check("stall_idle", res_valid, 1'b0);
        end else begin
          check("stall_vld", res_valid, 1'b1);
          check("stall_lzc", res_lzc, slzc[s_res[k]]);
          check("stall_mant", res_mant, norm(smant[s_res[k]], smant[s_res[k]] << slzc[s_res[k]]));
        end
        req0_valid = (idx < 4);
        req0_mant  = (idx < 4) ? smant[idx] : 24'h0;
        req1_valid = (k >= 2 && k <= 4);
        req1_mant  = 24'hFFFFFF;
        #1;
        check("stall_rdy", {req1_ready, req0_ready}, {31'b0, s_rdy[k]});
        if (s_rdy[k]) idx++;
        tick();
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;

    // Reset with S1 and S2 occupied; last grant before reset was requester 1
    do_reset();
    res_ready = 1'b0; req1_valid = 1'b1; req1_mant = 24'h000800;
    tick();
    req1_mant = 24'h000400;
    tick();
    req1_valid = 1'b0;
    check("mid_vld", res_valid, 1'b1);
    rst_l = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_rst_rdy", {req1_ready, req0_ready}, 32'h0);
    tick();
    rst_l = 1'b1; res_ready = 1'b1;
    check("post_rst_vld", res_valid, 1'b0);
    req0_mant = 24'h020000; req1_mant = 24'h000002;
    #1;
    check("post_rst_grant", {req1_ready, req0_ready}, 32'h1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("post_rst_gap", res_valid, 1'b0);
    tick();
    check("post_rst_res_vld", res_valid, 1'b1);
    check("post_rst_res_own", res_owner, 1'b0);
    check("post_rst_res_lzc", res_lzc, 5'd6);
    tick();
    check("post_rst_drained", res_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fpu_lzd_sched.md
FPU_LZD_SCHED -- requirements
Module: fpu_lzd_sched

Interface
REQ-001 SHALL have parameter MANT_W, default 24, mantissa width scanned by the shared leading-zero detector (supported 8..32).
REQ-002 SHALL have parameter LZC_W, default 5, count width; SHALL satisfy 2**LZC_W > MANT_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_l  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1 each  operand offered by requester 0 (FMADD) / requester 1 (FADD).
REQ-006 SHALL have ports req0_mant / req1_mant  input  MANT_W each  mantissa to scan, MSB = bit MANT_W-1.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1 each  operand accepted this cycle when valid and ready are both high.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_owner  output  1  requester index (0/1) that issued the result.
REQ-011 SHALL have port res_lzc  output  LZC_W  leading-zero count of the issued mantissa.
REQ-012 SHALL have port res_zero  output  1  issued mantissa was all zeros.
REQ-013 SHALL have port res_mant  output  MANT_W  normalized mantissa (see REQ-030).

Function
REQ-014 SHALL share one leading-zero detector between the two requesters through a 2-stage pipeline: S1 (operand + owner register), S2 (count + result register).
REQ-015 SHALL assert res_valid exactly 2 cycles after an accepting handshake when no stall occurs; throughput one operand per cycle.
REQ-016 SHALL compute res_lzc as the number of consecutive zeros from bit MANT_W-1 downward; all-zero input gives res_lzc = MANT_W and res_zero = 1, else res_zero = 0.
REQ-017 SHALL arbitrate round-robin: with both valids high, grant the requester not granted on the most recent accepted handshake; with one valid high, grant it.
REQ-018 SHALL drive at most one of req0_ready/req1_ready high per cycle, and only to a requester whose valid is high.
REQ-019 SHALL update the round-robin pointer only on an accepted handshake; unaccepted requests leave it unchanged.
REQ-020 SHALL stall when res_valid=1 and res_ready=0: S2 holds all res_* outputs stable; S1 holds if occupied; both ready outputs low if S1 is occupied.
REQ-021 SHALL allow S1 to accept a new operand in a stall cycle only when S1 is empty (one-entry skid).
REQ-022 SHALL, on res_valid & res_ready with S1 occupied, load S2 from S1 in that same cycle (no bubble).
REQ-023 SHALL never drop, duplicate or reorder accepted operands; results issue in acceptance order.
REQ-024 SHALL leave res_owner/res_lzc/res_zero/res_mant as don't-care when res_valid=0, but SHALL not change them while res_valid=1 and res_ready=0.

Reset
REQ-025 SHALL, with rst_l low at a rising edge, clear res_valid, S1 valid flag, res_owner, res_lzc, res_zero, res_mant to 0.
REQ-026 SHALL reset the round-robin pointer so requester 0 wins the first contended cycle.
REQ-027 SHALL hold req0_ready and req1_ready low while rst_l is low.
REQ-028 SHALL discard in-flight S1/S2 contents on reset mid-operation; no result for those operands is ever issued.

Configuration
REQ-029 SHALL use macro FPU_LZD_NORM_SHIFT_EN to compile the normalizing shifter in or out.
REQ-030 SHALL, with FPU_LZD_NORM_SHIFT_EN defined, drive res_mant = issued mantissa shifted left by res_lzc, zero-filled (all-zero input gives 0), registered in S2 with the count.
REQ-031 SHALL, without FPU_LZD_NORM_SHIFT_EN, drive res_mant = issued mantissa unchanged; port list, latency and all other behaviour identical.

Verification
REQ-032 SHALL cover: req0 only, mant=0x00F000, res_ready=1 -> 2 cycles later res_valid=1, owner=0, lzc=8, zero=0, res_mant=0xF00000 (macro on) / 0x00F000 (off).
REQ-033 SHALL cover: both valid for 4 cycles after reset, res_ready=1 -> grants 0,1,0,1; results in the same order at 2-cycle latency.
REQ-034 SHALL cover: req1 mant=0x000000 -> lzc=24, zero=1, res_mant=0.
REQ-035 SHALL cover: res_ready low 3 cycles with a continuous stream -> S2 and S1 fill, both readys low, outputs stable; res_ready high -> results drain back-to-back, none lost.
REQ-036 SHALL cover: rst_l low one cycle with S1 and S2 occupied -> res_valid=0 next cycle, discarded operands never appear, next contended grant goes to requester 0.
REQ-037 SHALL cover: mant=0x800000 -> lzc=0; mant=0x000001 -> lzc=23, res_mant=0x800000 with macro on.
